// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game controller.
//   state_t   : game FSM state encoding
//   LFSR_*    : width, reset seed and feedback taps of the mole-select LFSR
//   idx_w()   : bits needed to index a mole
package whack_pkg;

  typedef enum logic [2:0] {
    S_START,
    S_ARM,
    S_ACTIVE,
    S_WHACKED,
    S_MISSED,
    S_PAUSE,
    S_GAME_OVER
  } state_t;

  localparam int              LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form (maximal length)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/whack_lfsr.sv
// 16-bit maximal-length Galois LFSR used to pick the next mole.
// Advances every cycle; synchronous active-high reset loads the seed.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   rnd  : low OUT_W bits of the current LFSR state
module whack_lfsr
  import whack_pkg::*;
#(
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] rnd
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game controller.
// Raises one mole at a time for a shrinking active window, scores correct
// button presses, charges a life for wrong presses or timeouts, and ends the
// game when lives run out.
// Ports:
//   clk              : clock, rising edge
//   Reset            : synchronous active-high reset
//   go               : start/restart request (rising edge is the event)
//   whack            : one button per mole (rising edges are the events)
//   mole_onehot      : currently raised mole, zero outside the active window
//   score            : hit count, saturating
//   lives_left       : remaining lives
//   successful_whack : one-cycle hit pulse
//   missed           : one-cycle miss pulse
//   game_over        : high while the game is over
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int NUM_MOLES    = 4,
  parameter int SCORE_W      = 8,
  parameter int LIVES        = 3,
  parameter int MOLE_TIMEOUT = 8,
  parameter int MIN_TIMEOUT  = 4,
  parameter int TIMEOUT_STEP = 2,
  parameter int PAUSE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 go,
  input  logic [NUM_MOLES-1:0] whack,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           lives_left,
  output logic                 successful_whack,
  output logic                 missed,
  output logic                 game_over
);

  localparam int IDX_W = idx_w(NUM_MOLES);
  // One timer serves both the active window and the pause gap
  localparam int T_MAX = (MOLE_TIMEOUT > PAUSE_CYCLES) ? MOLE_TIMEOUT : PAUSE_CYCLES;
  localparam int TMR_W = $clog2(T_MAX + 1);

  state_t               state_q, state_d;
  logic                 go_prev_q, go_prev_d;
  logic [NUM_MOLES-1:0] whack_prev_q, whack_prev_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           lives_q, lives_d;
  logic [TMR_W-1:0]     window_q, window_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [IDX_W-1:0]     lfsr_low;
  logic                 go_edge;
  logic [NUM_MOLES-1:0] whack_edge;
  logic [NUM_MOLES-1:0] mole_vec;

  whack_lfsr #(.OUT_W(IDX_W)) u_lfsr (
    .clk (clk),
    .rst (Reset),
    .rnd (lfsr_low)
  );

  assign go_edge    = go & ~go_prev_q;
  assign whack_edge = whack & ~whack_prev_q;
  assign mole_vec   = {{(NUM_MOLES-1){1'b0}}, 1'b1} << idx_q;

  always_comb begin
    state_d      = state_q;
    go_prev_d    = go;
    whack_prev_d = whack;
    score_d      = score_q;
    lives_d      = lives_q;
    window_d     = window_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    case (state_q)
      S_START: begin
        score_d  = '0;
        lives_d  = 4'(LIVES);
        window_d = TMR_W'(MOLE_TIMEOUT);
        timer_d  = '0;
        if (go_edge) state_d = S_ARM;
      end
      S_ARM: begin
        // Never raise the same mole twice in a row
        idx_d   = (lfsr_low == idx_q) ? idx_q + IDX_W'(1) : lfsr_low;
        timer_d = '0;
        state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        // A correct press beats a timeout landing on the same cycle
        if (whack_edge == mole_vec)              state_d = S_WHACKED;
        else if (whack_edge != '0)               state_d = S_MISSED;
        else if (timer_q == window_q - TMR_W'(1)) state_d = S_MISSED;
        else                                     timer_d = timer_q + TMR_W'(1);
      end
      S_WHACKED: begin
        if (score_q != '1) score_d = score_q + SCORE_W'(1);
        if (int'(window_q) >= MIN_TIMEOUT + TIMEOUT_STEP)
          window_d = window_q - TMR_W'(TIMEOUT_STEP);
        else
          window_d = TMR_W'(MIN_TIMEOUT);
        timer_d = '0;
        state_d = S_PAUSE;
      end
      S_MISSED: begin
        lives_d = lives_q - 4'd1;
        timer_d = '0;
        state_d = (lives_q == 4'd1) ? S_GAME_OVER : S_PAUSE;
      end
      S_PAUSE: begin
        if (timer_q == TMR_W'(PAUSE_CYCLES - 1)) state_d = S_ARM;
        else                                     timer_d = timer_q + TMR_W'(1);
      end
      S_GAME_OVER: begin
        if (go_edge) state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= S_START;
      go_prev_q    <= 1'b0;
      whack_prev_q <= '0;
      score_q      <= '0;
      lives_q      <= 4'(LIVES);
      window_q     <= TMR_W'(MOLE_TIMEOUT);
      timer_q      <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      go_prev_q    <= go_prev_d;
      whack_prev_q <= whack_prev_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      window_q     <= window_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
    end
  end

  assign mole_onehot      = (state_q == S_ACTIVE) ? mole_vec : '0;
  assign score            = score_q;
  assign lives_left       = lives_q;
  assign successful_whack = (state_q == S_WHACKED);
  assign missed           = (state_q == S_MISSED);
  assign game_over        = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Self-checking bench for whack_game_ctrl with a score/lives/window model.
module tb_whack_game_ctrl;

  logic       clk = 1'b0;
  logic       Reset, go;
  logic [3:0] whack, mole_onehot;
  logic [7:0] score;
  logic [3:0] lives_left;
  logic       successful_whack, missed, game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int m_score, m_lives, m_window;

  always #5 clk = ~clk;

  whack_game_ctrl #(
    .NUM_MOLES(4), .SCORE_W(8), .LIVES(3), .MOLE_TIMEOUT(8),
    .MIN_TIMEOUT(4), .TIMEOUT_STEP(2), .PAUSE_CYCLES(3)
  ) dut (
    .clk(clk), .Reset(Reset), .go(go), .whack(whack),
    .mole_onehot(mole_onehot), .score(score), .lives_left(lives_left),
    .successful_whack(successful_whack), .missed(missed), .game_over(game_over)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_game_model;
    m_score = 0; m_lives = 3; m_window = 8;
  endtask

  task automatic model_hit;
    m_score  = (m_score < 255) ? m_score + 1 : 255;
    m_window = (m_window - 2 < 4) ? 4 : m_window - 2;
  endtask

  task automatic do_reset;
    Reset = 1'b1; go = 1'b0; whack = '0;
    tick; tick;
    Reset = 1'b0;
    new_game_model();
  endtask

  task automatic start_game;
    go = 1'b1; tick; go = 1'b0;
  endtask

  // mode 0: no press (timeout); 1: correct press at timer=at; 2: wrong vector at timer=at
  task automatic run_round(input int mode, input int at, output int idx, output int len,
                           output bit hit, output bit miss, output bit tmo, output bit oh_ok);
    int guard;
    logic [3:0] v;
    hit = 0; miss = 0; tmo = 0; len = 0; idx = -1; oh_ok = 1; guard = 0;
    while (mole_onehot == 4'd0 && guard < 100) begin tick; guard++; end
    if (mole_onehot == 4'd0) begin tmo = 1; return; end
    for (int i = 0; i < 4; i++) if (mole_onehot[i]) idx = i;
    while (mole_onehot != 4'd0 && len < 64) begin
      if ($countones(mole_onehot) != 1 || !mole_onehot[idx]) oh_ok = 0;
      if (len == at && mode == 1) whack = 4'(1 << idx);
      if (len == at && mode == 2) begin
        do v = 4'($urandom_range(1, 15)); while (v == 4'(1 << idx));
        whack = v;
      end
      len++;
      tick;
    end
    if (mole_onehot != 4'd0) begin tmo = 1; return; end
    hit = successful_whack; miss = missed;
    tick;
    whack = '0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
    n_tests++; if (lives_left !== 4'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives_left); end
    n_tests++; if (mole_onehot !== 4'd0) begin n_fail++; $display("FAIL reset_mole: got %b want 0000", mole_onehot); end
    n_tests++; if ({successful_whack, missed, game_over} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {successful_whack, missed, game_over}); end
  endtask

  task automatic test_first_hit;
    int idx, len; bit hit, miss, tmo, ok;
    do_reset(); start_game();
    run_round(1, 2, idx, len, hit, miss, tmo, ok);
    model_hit();
    n_tests++; if ({tmo, hit, miss} !== 3'b010) begin n_fail++; $display("FAIL first_hit tmo/hit/miss: got %b want 010", {tmo, hit, miss}); end
    n_tests++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL first_hit score: got %0d want %0d", score, m_score); end
    n_tests++; if (successful_whack !== 1'b0) begin n_fail++; $display("FAIL first_hit pulse_len: got %b want 0", successful_whack); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (mole_onehot !== 4'd0) begin n_fail++; $display("FAIL first_hit pause%0d: got %b want 0000", i, mole_onehot); end
      tick;
    end
    run_round(0, 0, idx, len, hit, miss, tmo, ok);
    m_lives--;
    n_tests++; if (len !== m_window) begin n_fail++; $display("FAIL first_hit window: got %0d want %0d", len, m_window); end
    n_tests++; if ({tmo, hit, miss} !== 3'b001) begin n_fail++; $display("FAIL first_hit timeout: got %b want 001", {tmo, hit, miss}); end
    n_tests++; if (lives_left !== 4'(m_lives)) begin n_fail++; $display("FAIL first_hit lives: got %0d want %0d", lives_left, m_lives); end
  endtask

  task automatic test_timeouts;
    int idx, len; bit hit, miss, tmo, ok;
    do_reset(); start_game();
    run_round(1, $urandom_range(0, 7), idx, len, hit, miss, tmo, ok);
    model_hit();
    for (int r = 0; r < 3; r++) begin
      run_round(0, 0, idx, len, hit, miss, tmo, ok);
      m_lives--;
      n_tests++; if (len !== m_window || {tmo, hit, miss} !== 3'b001) begin n_fail++; $display("FAIL timeout%0d len/flags: got %0d/%b want %0d/001", r, len, {tmo, hit, miss}, m_window); end
      n_tests++; if (lives_left !== 4'(m_lives)) begin n_fail++; $display("FAIL timeout%0d lives: got %0d want %0d", r, lives_left, m_lives); end
    end
    n_tests++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL timeouts game_over: got %b want 1", game_over); end
    for (int i = 0; i < 10; i++) tick;
    n_tests++; if ({game_over, mole_onehot, score} !== {1'b1, 4'd0, 8'(m_score)}) begin n_fail++; $display("FAIL timeouts held: got go=%b mole=%b score=%0d want 1/0000/%0d", game_over, mole_onehot, score, m_score); end
  endtask

  task automatic test_window_floor;
    int idx, len, at; bit hit, miss, tmo, ok;
    do_reset(); start_game();
    for (int k = 0; k < 4; k++) begin
      at = m_window - 1;
      run_round(1, at, idx, len, hit, miss, tmo, ok);
      model_hit();
      n_tests++; if ({tmo, hit, miss} !== 3'b010) begin n_fail++; $display("FAIL floor hit%0d at %0d: got %b want 010", k, at, {tmo, hit, miss}); end
    end
    n_tests++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL floor score: got %0d want %0d", score, m_score); end
    run_round(0, 0, idx, len, hit, miss, tmo, ok);
    m_lives--;
    n_tests++; if (len !== m_window) begin n_fail++; $display("FAIL floor window: got %0d want %0d", len, m_window); end
    run_round(2, 1, idx, len, hit, miss, tmo, ok);
    m_lives--;
    n_tests++; if ({tmo, hit, miss} !== 3'b001) begin n_fail++; $display("FAIL wrong_button flags: got %b want 001", {tmo, hit, miss}); end
    n_tests++; if (lives_left !== 4'(m_lives)) begin n_fail++; $display("FAIL wrong_button lives: got %0d want %0d", lives_left, m_lives); end
  endtask

  task automatic test_held_whack;
    int idx, len; bit hit, miss, tmo, ok;
    do_reset(); start_game();
    run_round(1, 0, idx, len, hit, miss, tmo, ok);
    model_hit();
    whack = 4'hF;
    run_round(0, 0, idx, len, hit, miss, tmo, ok);
    m_lives--;
    n_tests++; if ({tmo, hit, miss} !== 3'b001 || len !== m_window) begin n_fail++; $display("FAIL held_whack: got %b len %0d want 001 len %0d", {tmo, hit, miss}, len, m_window); end
    n_tests++; if (lives_left !== 4'(m_lives)) begin n_fail++; $display("FAIL held_whack lives: got %0d want %0d", lives_left, m_lives); end
  endtask

  task automatic test_random_rounds;
    int idx, len, at, mode, prev, repeats, exp_len; bit hit, miss, tmo, ok;
    logic [3:0] seen;
    do_reset(); start_game();
    prev = -1; repeats = 0; seen = '0;
    for (int r = 0; r < 200; r++) begin
      at = $urandom_range(0, 9);
      mode = (m_lives > 1 && at == 0) ? 0 : (m_lives > 1 && at == 1) ? 2 : 1;
      at = $urandom_range(0, m_window - 1);
      exp_len = (mode == 0) ? m_window : at + 1;
      run_round(mode, at, idx, len, hit, miss, tmo, ok);
      if (mode == 1) model_hit(); else m_lives--;
      if (idx >= 0) begin
        if (idx == prev) repeats++;
        seen = seen | 4'(1 << idx);
      end
      prev = idx;
      n_tests++; if ({tmo, ok, hit, miss} !== {2'b01, mode == 1, mode != 1} || len !== exp_len) begin n_fail++; $display("FAIL rand%0d mode %0d: got tmo/ok/hit/miss %b len %0d want %b len %0d", r, mode, {tmo, ok, hit, miss}, len, {2'b01, mode == 1, mode != 1}, exp_len); end
      n_tests++; if (score !== 8'(m_score) || lives_left !== 4'(m_lives)) begin n_fail++; $display("FAIL rand%0d score/lives: got %0d/%0d want %0d/%0d", r, score, lives_left, m_score, m_lives); end
    end
    n_tests++; if (repeats !== 0) begin n_fail++; $display("FAIL rand repeats: got %0d want 0", repeats); end
    n_tests++; if (seen !== 4'hF) begin n_fail++; $display("FAIL rand coverage: got %b want 1111", seen); end
  endtask

  task automatic test_reset_mid;
    int idx, len, guard; bit hit, miss, tmo, ok, any;
    do_reset(); start_game();
    run_round(1, 1, idx, len, hit, miss, tmo, ok);
    guard = 0;
    while (mole_onehot == 4'd0 && guard < 100) begin tick; guard++; end
    n_tests++; if (mole_onehot === 4'd0) begin n_fail++; $display("FAIL reset_mid active: got %b want nonzero", mole_onehot); end
    Reset = 1'b1; tick; Reset = 1'b0;
    new_game_model();
    n_tests++; if ({mole_onehot, score, lives_left, game_over} !== {4'd0, 8'd0, 4'd3, 1'b0}) begin n_fail++; $display("FAIL reset_mid state: got mole=%b score=%0d lives=%0d go=%b want 0000/0/3/0", mole_onehot, score, lives_left, game_over); end
    any = 0;
    for (int i = 0; i < 15; i++) begin if (mole_onehot != 4'd0) any = 1; tick; end
    n_tests++; if (any !== 1'b0) begin n_fail++; $display("FAIL reset_mid idle: got mole raised want none"); end
    start_game();
    run_round(1, 0, idx, len, hit, miss, tmo, ok);
    n_tests++; if ({tmo, hit} !== 2'b01) begin n_fail++; $display("FAIL reset_mid restart: got %b want 01", {tmo, hit}); end
  endtask

  task automatic test_go_held;
    int idx, len; bit hit, miss, tmo, ok, any;
    do_reset(); start_game();
    run_round(1, 0, idx, len, hit, miss, tmo, ok);
    for (int r = 0; r < 3; r++) run_round(2, 0, idx, len, hit, miss, tmo, ok);
    n_tests++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL go_held game_over: got %b want 1", game_over); end
    go = 1'b1; tick;
    n_tests++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL go_held leave: got %b want 0", game_over); end
    any = 0;
    for (int i = 0; i < 20; i++) begin if (mole_onehot != 4'd0) any = 1; tick; end
    n_tests++; if (any !== 1'b0) begin n_fail++; $display("FAIL go_held no_start: got mole raised want none"); end
    n_tests++; if ({score, lives_left} !== {8'd0, 4'd3}) begin n_fail++; $display("FAIL go_held start_vals: got %0d/%0d want 0/3", score, lives_left); end
    go = 1'b0; tick;
    start_game();
    run_round(1, 0, idx, len, hit, miss, tmo, ok);
    n_tests++; if ({tmo, hit} !== 2'b01) begin n_fail++; $display("FAIL go_held restart: got %b want 01", {tmo, hit}); end
  endtask

  initial begin
    Reset = 1'b1; go = 1'b0; whack = '0;
    test_reset();
    test_first_hit();
    test_timeouts();
    test_window_floor();
    test_held_whack();
    test_random_rounds();
    test_reset_mid();
    test_go_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/whack_game_ctrl.md
WHACK_GAME_CTRL -- requirements
Module: whack_game_ctrl

Interface
REQ-001 SHALL have parameter NUM_MOLES, 4, mole count; power of two, 2..16.
REQ-002 SHALL have parameter SCORE_W, 8, score width in bits.
REQ-003 SHALL have parameter LIVES, 3, misses allowed per game, 1..15.
REQ-004 SHALL have parameter MOLE_TIMEOUT, 8, initial active-window length in cycles.
REQ-005 SHALL have parameter MIN_TIMEOUT, 4, floor on the active window; 1 <= MIN_TIMEOUT <= MOLE_TIMEOUT.
REQ-006 SHALL have parameter TIMEOUT_STEP, 2, window reduction applied per hit.
REQ-007 SHALL have parameter PAUSE_CYCLES, 3, mole-off gap between rounds, >= 1.
REQ-008 SHALL have port clk, input, 1, single clock, rising edge.
REQ-009 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-010 SHALL have port go, input, 1, start/restart request, level.
REQ-011 SHALL have port whack, input, NUM_MOLES, one bit per mole button, level.
REQ-012 SHALL have port mole_onehot, output, NUM_MOLES, currently raised mole.
REQ-013 SHALL have port score, output, SCORE_W, hit count.
REQ-014 SHALL have port lives_left, output, 4, remaining lives.
REQ-015 SHALL have port successful_whack, output, 1, one-cycle hit pulse.
REQ-016 SHALL have port missed, output, 1, one-cycle miss pulse.
REQ-017 SHALL have port game_over, output, 1, high throughout S_GAME_OVER.

Function
REQ-018 SHALL implement states S_START, S_ARM, S_ACTIVE, S_WHACKED, S_MISSED, S_PAUSE, S_GAME_OVER.
REQ-019 SHALL edge-detect go and every whack bit with registered previous values; only 0->1 transitions count as events.
REQ-020 S_START: score=0, lives_left=LIVES, window=MOLE_TIMEOUT; go edge -> S_ARM.
REQ-021 S_ARM (1 cycle): mole index = LFSR low log2(NUM_MOLES) bits; if equal to previous index, use previous+1 mod NUM_MOLES; -> S_ACTIVE.
REQ-022 S_ACTIVE: mole_onehot = one-hot of index; cycle timer counts from 0.
REQ-023 S_ACTIVE: whack-edge vector exactly equal to mole_onehot -> S_WHACKED; any other nonzero edge vector (wrong or multiple buttons) -> S_MISSED.
REQ-024 S_ACTIVE: timer reaching window-1 with no edge -> S_MISSED; a correct edge on that same cycle SHALL win (S_WHACKED).
REQ-025 S_WHACKED (1 cycle): successful_whack=1; score += 1, saturating at all-ones; window = max(window-TIMEOUT_STEP, MIN_TIMEOUT); -> S_PAUSE.
REQ-026 S_MISSED (1 cycle): missed=1; lives_left -= 1; -> S_GAME_OVER if lives_left was 1, else S_PAUSE.
REQ-027 S_PAUSE: mole_onehot=0 for PAUSE_CYCLES cycles, whack edges ignored; then -> S_ARM.
REQ-028 S_GAME_OVER: game_over=1, score and lives_left held; go edge -> S_START.
REQ-029 mole_onehot SHALL be zero in every state other than S_ACTIVE; outputs registered or decoded from registered state only.
REQ-030 A go held high through S_GAME_OVER -> S_START SHALL NOT start a new game without a fresh rising edge.

Reset
REQ-031 Reset SHALL force S_START, score=0, lives_left=LIVES, window=MOLE_TIMEOUT, timer=0, previous index=0, edge registers=0, all pulses and game_over=0, LFSR=nonzero seed 16'hACE1; Reset mid-game SHALL abandon the round on the next edge.

Structure
REQ-032 State encodings, LFSR width/seed, and index-width function SHALL live in shared package whack_pkg.
REQ-033 SHALL instantiate sub-module whack_lfsr: 16-bit maximal Galois LFSR, advancing every cycle, synchronous reset to seed.

Verification (NUM_MOLES=4, LIVES=3, MOLE_TIMEOUT=8, MIN_TIMEOUT=4, TIMEOUT_STEP=2, PAUSE_CYCLES=3)
REQ-034 Reset, go pulse, correct whack edge 2 cycles into S_ACTIVE -> successful_whack one cycle, score=1, window=6, mole_onehot=0 for 3 cycles.
REQ-035 No whack for 8 cycles -> missed pulse, lives_left=2; third consecutive timeout -> game_over=1, score held.
REQ-036 Four hits -> windows 6,4,4,4 (floor held); wrong-button edge -> miss, lives_left decrements.
REQ-037 Correct whack on timer=7 -> hit, not miss; whack held high from S_PAUSE into S_ACTIVE -> no event.
REQ-038 Over 200 rounds, consecutive mole indices never equal and all 4 occur.
REQ-039 Reset asserted mid-S_ACTIVE -> next cycle S_START, score=0, lives_left=3, mole_onehot=0; go held high from game over -> stays S_START until go toggles.
